// File: rtl/mc_ctrl_fsm_if.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm_if
//   Bundles every signal between the multi-cycle control unit and the datapath
//   it steers (memory handshake, register file addressing, mux selects, debug).
//
//   Modports:
//     master - the control unit: samples memory/ALU status, drives all controls.
//     slave  - the datapath side (or a testbench acting as one).
//
//   Signals:
//     mem_rdata  [31:0]  instruction or load data from memory
//     mem_ready          memory access completes this cycle
//     alu_zero           ALU zero flag (combinational)
//     r1_addr/r2_addr    register file read addresses (IR[25:21], IR[20:16])
//     r3_addr            register file write address
//     r3_wr              register file write enable
//     mem_to_reg         writeback select: 1 = memory data, 0 = ALUOut
//     ir_wr              IR load strobe (debug)
//     pc_wr, pc_src      PC write enable and source select
//     iord, mem_rd, mem_wr  memory address select and read/write requests
//     alu_src_a, alu_src_b, alu_op  ALU operand and operation selects
//     illegal            one-cycle pulse on an unsupported instruction
//     state              current controller state (debug)
//     retired            retired-instruction counter
// -----------------------------------------------------------------------------
interface mc_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      mem_rdata;
  logic             mem_ready;
  logic             alu_zero;
  logic [4:0]       r1_addr;
  logic [4:0]       r2_addr;
  logic [4:0]       r3_addr;
  logic             r3_wr;
  logic             mem_to_reg;
  logic             ir_wr;
  logic             pc_wr;
  logic [1:0]       pc_src;
  logic             iord;
  logic             mem_rd;
  logic             mem_wr;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  mem_rdata, mem_ready, alu_zero,
    output r1_addr, r2_addr, r3_addr, r3_wr, mem_to_reg, ir_wr,
           pc_wr, pc_src, iord, mem_rd, mem_wr,
           alu_src_a, alu_src_b, alu_op, illegal, state, retired
  );

  modport slave (
    output mem_rdata, mem_ready, alu_zero,
    input  r1_addr, r2_addr, r3_addr, r3_wr, mem_to_reg, ir_wr,
           pc_wr, pc_src, iord, mem_rd, mem_wr,
           alu_src_a, alu_src_b, alu_op, illegal, state, retired
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mc_ctrl_fsm
//   Multi-cycle control unit for a MIPS subset (R-type add/sub/and/or/slt,
//   lw, sw, beq, addi, j). Holds the instruction register, sequences the
//   datapath through fetch/decode/execute/memory/writeback and supplies every
//   mux select and enable. Counts retired instructions.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    mc_ctrl_fsm_if.master - memory handshake, register file
//            addressing, datapath controls and debug outputs
// -----------------------------------------------------------------------------
module mc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [CNT_W-1:0] retired_q;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype;
  logic       funct_ok;

  // Raw strobes before reset gating; retire/ir_load drive internal state.
  logic ir_load;
  logic retire;
  logic r3_wr_raw;
  logic pc_wr_raw;
  logic mem_wr_raw;
  logic illegal_raw;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign is_rtype = (opcode == OP_RTYPE);

  always_comb begin
    unique case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default:                                               funct_ok = 1'b0;
    endcase
  end

  // Register addresses come straight from IR; only the write address depends
  // on the instruction format.
  assign bus.r1_addr = ir_q[25:21];
  assign bus.r2_addr = ir_q[20:16];
  assign bus.r3_addr = is_rtype ? ir_q[15:11] : ir_q[20:16];

  // Next-state and control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    state_d        = state_q;
    ir_load        = 1'b0;
    retire         = 1'b0;
    r3_wr_raw      = 1'b0;
    pc_wr_raw      = 1'b0;
    mem_wr_raw     = 1'b0;
    illegal_raw    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.pc_src     = 2'b00;
    bus.iord       = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        // PC + 4 is computed and written in the same cycle the instruction
        // arrives, so both strobes follow mem_ready directly.
        bus.mem_rd    = 1'b1;
        bus.alu_src_b = 2'b01;
        ir_load       = bus.mem_ready;
        pc_wr_raw     = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        bus.alu_src_b = 2'b11;
        unique case (opcode)
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_R_EXEC;
            end else begin
              state_d     = S_FETCH;
              illegal_raw = 1'b1;
            end
          end
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            state_d     = S_FETCH;
            illegal_raw = 1'b1;
          end
        endcase
      end

      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        bus.mem_rd = 1'b1;
        bus.iord   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        r3_wr_raw      = 1'b1;
        bus.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = S_FETCH;
      end

      S_MEM_WRITE: begin
        // mem_wr stays up through the accepting cycle; the store retires then.
        mem_wr_raw = 1'b1;
        bus.iord   = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b10;
        state_d       = S_R_WB;
      end

      S_R_WB, S_ADDI_WB: begin
        r3_wr_raw = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = 2'b01;
        bus.pc_src    = 2'b01;
        pc_wr_raw     = bus.alu_zero;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end

      S_JUMP: begin
        bus.pc_src = 2'b10;
        pc_wr_raw  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      S_ADDI_EX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Side-effecting strobes are held off combinationally while reset is low,
  // so an in-flight access cannot write anything during the reset cycle.
  assign bus.r3_wr   = r3_wr_raw   & rst_n;
  assign bus.pc_wr   = pc_wr_raw   & rst_n;
  assign bus.mem_wr  = mem_wr_raw  & rst_n;
  assign bus.ir_wr   = ir_load     & rst_n;
  assign bus.illegal = illegal_raw & rst_n;

  assign bus.state   = state_q;
  assign bus.retired = retired_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) ir_q      <= bus.mem_rdata;
      if (retire)  retired_q <= retired_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl_fsm
//   Self-checking bench for mc_ctrl_fsm. A table of per-cycle vectors
//   ({inputs, expected outputs}) walks the controller through every supported
//   instruction, memory stalls, illegal opcodes/functs and a mid-store reset.
//   A hand-written sequence then preloads the retired counter and checks wrap.
//   Per-state mux selects come from a small reference table of the control
//   encoding.
// -----------------------------------------------------------------------------
module tb_mc_ctrl_fsm;

  localparam int CNT_W = 32;

  localparam logic [31:0] I_ADD    = 32'h0022_1820; // add  $3,$1,$2
  localparam logic [31:0] I_LW     = 32'h8C85_0008; // lw   $5,8($4)
  localparam logic [31:0] I_BEQ    = 32'h1022_0003; // beq  $1,$2,3
  localparam logic [31:0] I_BAD_OP = 32'hFC00_0000; // opcode 111111
  localparam logic [31:0] I_BAD_FN = 32'h0022_1803; // R-type funct 000011
  localparam logic [31:0] I_J      = 32'h0800_0010; // j    0x10
  localparam logic [31:0] I_ADDI   = 32'h2026_0005; // addi $6,$1,5
  localparam logic [31:0] I_SW     = 32'hAC85_0004; // sw   $5,4($4)

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.CNT_W(CNT_W)) bus ();

  mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] rdata;
    logic        rdy;
    logic        zero;
    logic [3:0]  st;
    logic        r3w;
    logic        pcw;
    logic        irw;
    logic        mw;
    logic        ill;
    logic [31:0] ret;
    logic        chk;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  r3;
  } vec_t;

  typedef struct packed {
    logic       mem_rd;
    logic       iord;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] op;
    logic [1:0] pc_src;
    logic       m2r;
  } ctrl_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  function automatic vec_t v(input logic rst_i, input logic [31:0] rdata,
                             input logic rdy, input logic zero,
                             input logic [3:0] st, input logic r3w,
                             input logic pcw, input logic irw, input logic mw,
                             input logic ill, input logic [31:0] ret,
                             input logic chk = 1'b0, input logic [4:0] r1 = 5'd0,
                             input logic [4:0] r2 = 5'd0, input logic [4:0] r3 = 5'd0);
    vec_t x;
    x.rst_n = rst_i; x.rdata = rdata; x.rdy = rdy; x.zero = zero;
    x.st = st; x.r3w = r3w; x.pcw = pcw; x.irw = irw; x.mw = mw; x.ill = ill;
    x.ret = ret; x.chk = chk; x.r1 = r1; x.r2 = r2; x.r3 = r3;
    return x;
  endfunction

  // Reference control encoding per state.
  function automatic ctrl_t ctrl_of(input logic [3:0] st);
    ctrl_t c;
    c = '0;
    case (st)
      4'd0:        begin c.mem_rd = 1'b1; c.src_b = 2'b01; end
      4'd1:        c.src_b = 2'b11;
      4'd2, 4'd10: begin c.src_a = 1'b1; c.src_b = 2'b10; end
      4'd3:        begin c.mem_rd = 1'b1; c.iord = 1'b1; end
      4'd4:        c.m2r = 1'b1;
      4'd5:        c.iord = 1'b1;
      4'd6:        begin c.src_a = 1'b1; c.op = 2'b10; end
      4'd8:        begin c.src_a = 1'b1; c.op = 2'b01; c.pc_src = 2'b01; end
      4'd9:        c.pc_src = 2'b10;
      default:     c = '0;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector after the falling edge, then compare once it settles.
  task automatic apply(input vec_t x);
    vec_t  e;
    ctrl_t act_c;
    @(negedge clk);
    rst_n         = x.rst_n;
    bus.mem_rdata = x.rdata;
    bus.mem_ready = x.rdy;
    bus.alu_zero  = x.zero;
    exp_q.push_back(x);
    #1;
    e = exp_q.pop_front();
    act_c = '{bus.mem_rd, bus.iord, bus.alu_src_a, bus.alu_src_b,
              bus.alu_op, bus.pc_src, bus.mem_to_reg};
    check($sformatf("v%0d state", vec_idx),   {28'd0, bus.state}, {28'd0, e.st});
    check($sformatf("v%0d r3_wr", vec_idx),   {31'd0, bus.r3_wr}, {31'd0, e.r3w});
    check($sformatf("v%0d pc_wr", vec_idx),   {31'd0, bus.pc_wr}, {31'd0, e.pcw});
    check($sformatf("v%0d ir_wr", vec_idx),   {31'd0, bus.ir_wr}, {31'd0, e.irw});
    check($sformatf("v%0d mem_wr", vec_idx),  {31'd0, bus.mem_wr}, {31'd0, e.mw});
    check($sformatf("v%0d illegal", vec_idx), {31'd0, bus.illegal}, {31'd0, e.ill});
    check($sformatf("v%0d retired", vec_idx), bus.retired, e.ret);
    check($sformatf("v%0d ctrl", vec_idx),    {22'd0, act_c}, {22'd0, ctrl_of(e.st)});
    if (e.chk) begin
      check($sformatf("v%0d addrs", vec_idx),
            {17'd0, bus.r1_addr, bus.r2_addr, bus.r3_addr},
            {17'd0, e.r1, e.r2, e.r3});
    end
    vec_idx++;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
    bus.alu_zero  = 1'b0;
    repeat (2) @(posedge clk);

    // rst_n, rdata, rdy, zero, state, r3w, pcw, irw, mw, ill, retired [, addrs]
    // Reset held: strobes gated even though FETCH sees mem_ready; IR = 0.
    vecs.push_back(v(0, I_ADD, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0));
    // add $3,$1,$2 : 0,1,6,7
    vecs.push_back(v(1, I_ADD, 1, 0, 4'd0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, '0,    1, 0, 4'd6, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, '0,    1, 0, 4'd7, 1, 0, 0, 0, 0, 0, 1, 5'd1, 5'd2, 5'd3));
    // lw $5,8($4) with two stall cycles in MEM_READ : 7 cycles
    vecs.push_back(v(1, I_LW,  1, 0, 4'd0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, '0,    1, 0, 4'd2, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, '0,    0, 0, 4'd3, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, '0,    0, 0, 4'd3, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, '0,    1, 0, 4'd3, 0, 0, 0, 0, 0, 1));
    vecs.push_back(v(1, '0,    1, 0, 4'd4, 1, 0, 0, 0, 0, 1, 1, 5'd4, 5'd5, 5'd5));
    // beq taken
    vecs.push_back(v(1, I_BEQ, 1, 0, 4'd0, 0, 1, 1, 0, 0, 2));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 2));
    vecs.push_back(v(1, '0,    1, 1, 4'd8, 0, 1, 0, 0, 0, 2));
    // beq not taken
    vecs.push_back(v(1, I_BEQ, 1, 0, 4'd0, 0, 1, 1, 0, 0, 3));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 3));
    vecs.push_back(v(1, '0,    1, 0, 4'd8, 0, 0, 0, 0, 0, 3));
    // illegal opcode, then illegal funct: not retired
    vecs.push_back(v(1, I_BAD_OP, 1, 0, 4'd0, 0, 1, 1, 0, 0, 4));
    vecs.push_back(v(1, '0,       1, 0, 4'd1, 0, 0, 0, 0, 1, 4));
    vecs.push_back(v(1, I_BAD_FN, 1, 0, 4'd0, 0, 1, 1, 0, 0, 4));
    vecs.push_back(v(1, '0,       1, 0, 4'd1, 0, 0, 0, 0, 1, 4));
    // j
    vecs.push_back(v(1, I_J,   1, 0, 4'd0, 0, 1, 1, 0, 0, 4));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 4));
    vecs.push_back(v(1, '0,    1, 0, 4'd9, 0, 1, 0, 0, 0, 4));
    // addi $6,$1,5
    vecs.push_back(v(1, I_ADDI, 1, 0, 4'd0, 0, 1, 1, 0, 0, 5));
    vecs.push_back(v(1, '0,     1, 0, 4'd1, 0, 0, 0, 0, 0, 5));
    vecs.push_back(v(1, '0,     1, 0, 4'd10, 0, 0, 0, 0, 0, 5));
    vecs.push_back(v(1, '0,     1, 0, 4'd11, 1, 0, 0, 0, 0, 5, 1, 5'd1, 5'd6, 5'd6));
    // sw with one stall cycle in MEM_WRITE
    vecs.push_back(v(1, I_SW,  1, 0, 4'd0, 0, 1, 1, 0, 0, 6));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 6));
    vecs.push_back(v(1, '0,    1, 0, 4'd2, 0, 0, 0, 0, 0, 6));
    vecs.push_back(v(1, '0,    0, 0, 4'd5, 0, 0, 0, 1, 0, 6));
    vecs.push_back(v(1, '0,    1, 0, 4'd5, 0, 0, 0, 1, 0, 6));
    // sw interrupted by reset while stalled in MEM_WRITE
    vecs.push_back(v(1, I_SW,  1, 0, 4'd0, 0, 1, 1, 0, 0, 7));
    vecs.push_back(v(1, '0,    1, 0, 4'd1, 0, 0, 0, 0, 0, 7));
    vecs.push_back(v(1, '0,    1, 0, 4'd2, 0, 0, 0, 0, 0, 7));
    vecs.push_back(v(1, '0,    0, 0, 4'd5, 0, 0, 0, 1, 0, 7));
    vecs.push_back(v(0, '0,    0, 0, 4'd5, 0, 0, 0, 0, 0, 7));
    vecs.push_back(v(1, I_ADD, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0));

    foreach (vecs[i]) apply(vecs[i]);

    // Counter wrap: preload all ones while idling in FETCH, then retire a j.
    force dut.retired_q = '1;
    #1;
    release dut.retired_q;
    #1;
    check("preload retired", bus.retired, 32'hFFFF_FFFF);
    apply(v(1, I_J, 1, 0, 4'd0, 0, 1, 1, 0, 0, 32'hFFFF_FFFF));
    apply(v(1, '0,  1, 0, 4'd1, 0, 0, 0, 0, 0, 32'hFFFF_FFFF));
    apply(v(1, '0,  1, 0, 4'd9, 0, 1, 0, 0, 0, 32'hFFFF_FFFF));
    apply(v(1, '0,  0, 0, 4'd0, 0, 0, 0, 0, 0, 32'h0000_0000));

    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
